// File: rtl/dcache_responder.sv
// 2-way set-associative write-back data cache with 2-word blocks, LL/SC link
// tracking and a halt-triggered flush that writes back every dirty frame.
module dcache_responder #(
    parameter int SETS = 8
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic        datomic,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload,
    output logic [3:0]  o_state
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 29 - IDX_W;

    typedef enum logic [3:0] {
        IDLE, WB0, WB1, AL0, AL1, FCHK, FWB0, FWB1, FDONE
    } state_t;

    state_t              r_state;
    logic [SETS-1:0]     r_valid [2];
    logic [SETS-1:0]     r_dirty [2];
    logic [SETS-1:0]     r_lru;
    logic [TAG_W-1:0]    r_tag   [2][SETS];
    logic [31:0]         r_data  [2][SETS][2];
    logic                r_way;
    logic [31:0]         r_fill0;
    logic [IDX_W:0]      r_fcnt;
    logic                r_flushed;
    logic                r_link_valid;
    logic [29:0]         r_link_addr;

    logic [TAG_W-1:0]    w_tag;
    logic [IDX_W-1:0]    w_idx;
    logic                w_off;
    logic                w_wr, w_rd, w_req, w_sc, w_ll;
    logic                w_link_match, w_sc_fail;
    logic                w_hit0, w_hit1, w_hit, w_hway;
    logic                w_idle_ok, w_sc_fast, w_hit_now, w_miss;
    logic                w_fway, w_flast, w_word;
    logic [IDX_W-1:0]    w_fset;
    logic                w_unused_addr_lsbs;

    assign w_tag = dmemaddr[31:3+IDX_W];
    assign w_idx = dmemaddr[2+IDX_W:3];
    assign w_off = dmemaddr[2];
    assign w_unused_addr_lsbs = ^dmemaddr[1:0];

    // Write wins when both strobes are (illegally) raised together.
    assign w_wr  = dmemWEN;
    assign w_rd  = dmemREN & ~dmemWEN;
    assign w_req = w_wr | w_rd;
    assign w_sc  = w_wr & datomic;
    assign w_ll  = w_rd & datomic;

    assign w_link_match = r_link_valid && (r_link_addr == dmemaddr[31:2]);
    assign w_sc_fail    = w_sc & ~w_link_match;

    assign w_hit0 = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
    assign w_hit1 = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
    assign w_hit  = w_hit0 | w_hit1;
    assign w_hway = w_hit1;

    // Halt in IDLE starts the flush and takes precedence over any request.
    assign w_idle_ok = (r_state == IDLE) && !halt && w_req;
    assign w_sc_fast = w_idle_ok & w_sc_fail;
    assign w_hit_now = w_idle_ok & ~w_sc_fail & w_hit;
    assign w_miss    = w_idle_ok & ~w_sc_fail & ~w_hit;

    assign dhit    = w_sc_fast | w_hit_now;
    assign flushed = r_flushed;
    assign o_state = r_state;

    // Flush walks way 0 over all sets, then way 1.
    assign w_fway  = r_fcnt[IDX_W];
    assign w_fset  = r_fcnt[IDX_W-1:0];
    assign w_flast = &r_fcnt;
    assign w_word  = (r_state == WB1) || (r_state == AL1) || (r_state == FWB1);

    always_comb begin
        dmemload = '0;
        if (w_hit_now) begin
            dmemload = w_sc ? 32'd1 : r_data[w_hway][w_idx][w_off];
        end
    end

    always_comb begin
        dREN   = 1'b0;
        dWEN   = 1'b0;
        daddr  = '0;
        dstore = '0;
        case (r_state)
            WB0, WB1: begin
                dWEN   = 1'b1;
                daddr  = {r_tag[r_way][w_idx], w_idx, w_word, 2'b00};
                dstore = r_data[r_way][w_idx][w_word];
            end
            AL0, AL1: begin
                dREN  = 1'b1;
                daddr = {w_tag, w_idx, w_word, 2'b00};
            end
            FWB0, FWB1: begin
                dWEN   = 1'b1;
                daddr  = {r_tag[w_fway][w_fset], w_fset, w_word, 2'b00};
                dstore = r_data[w_fway][w_fset][w_word];
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_state      <= IDLE;
            r_valid[0]   <= '0;
            r_valid[1]   <= '0;
            r_dirty[0]   <= '0;
            r_dirty[1]   <= '0;
            r_lru        <= '0;
            r_link_valid <= 1'b0;
            r_flushed    <= 1'b0;
            r_fcnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (halt) begin
                        r_state <= FCHK;
                        r_fcnt  <= '0;
                    end else if (w_hit_now) begin
                        r_lru[w_idx] <= ~w_hway;
                        if (w_wr) begin
                            r_data[w_hway][w_idx][w_off] <= dmemstore;
                            r_dirty[w_hway][w_idx]       <= 1'b1;
                        end
                        // A successful SC always matches the link, so this also retires it.
                        if (w_ll) begin
                            r_link_valid <= 1'b1;
                            r_link_addr  <= dmemaddr[31:2];
                        end else if (w_wr && w_link_match) begin
                            r_link_valid <= 1'b0;
                        end
                    end else if (w_miss) begin
                        r_way <= r_lru[w_idx];
                        if (r_valid[r_lru[w_idx]][w_idx] && r_dirty[r_lru[w_idx]][w_idx])
                            r_state <= WB0;
                        else
                            r_state <= AL0;
                    end
                end
                WB0: if (!dwait) r_state <= WB1;
                WB1: if (!dwait) r_state <= AL0;
                AL0: begin
                    if (!dwait) begin
                        r_fill0 <= dload;
                        r_state <= AL1;
                    end
                end
                AL1: begin
                    if (!dwait) begin
                        r_valid[r_way][w_idx]   <= 1'b1;
                        r_dirty[r_way][w_idx]   <= 1'b0;
                        r_tag[r_way][w_idx]     <= w_tag;
                        r_data[r_way][w_idx][0] <= r_fill0;
                        r_data[r_way][w_idx][1] <= dload;
                        r_state                 <= IDLE;
                    end
                end
                FCHK: begin
                    if (r_valid[w_fway][w_fset] && r_dirty[w_fway][w_fset]) begin
                        r_state <= FWB0;
                    end else if (w_flast) begin
                        r_state   <= FDONE;
                        r_flushed <= 1'b1;
                    end else begin
                        r_fcnt  <= r_fcnt + 1'b1;
                        r_state <= FCHK;
                    end
                end
                FWB0: if (!dwait) r_state <= FWB1;
                FWB1: begin
                    if (!dwait) begin
                        r_dirty[w_fway][w_fset] <= 1'b0;
                        if (w_flast) begin
                            r_state   <= FDONE;
                            r_flushed <= 1'b1;
                        end else begin
                            r_fcnt  <= r_fcnt + 1'b1;
                            r_state <= FCHK;
                        end
                    end
                end
                FDONE: ;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Randomised bench for dcache_responder: a flat golden memory plus a per-set
// recency list predicts data, hit/miss, write-back traffic and flush results.
module tb_dcache_responder;

    localparam int SETS      = 8;
    localparam int CYC_LIMIT = 200;

    logic        CLK = 1'b0;
    logic        nRST, halt, dmemREN, dmemWEN, datomic;
    logic [31:0] dmemaddr, dmemstore;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;
    logic        dwait;
    logic [31:0] dload;
    logic [3:0]  o_state;

    dcache_responder #(.SETS(SETS)) dut (
        .CLK(CLK), .nRST(nRST), .halt(halt),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload), .o_state(o_state)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- memory side ----------------
    logic [31:0] bmem [int];
    logic [31:0] gold [int];
    int          mem_mode   = 0;   // 0: never wait, 1: random waits, 2: stall first dREN cycles
    int          stall_left = 0;
    int          rd_count   = 0;
    int          wr_count   = 0;
    int          both_err   = 0;
    logic [31:0] rd_log[$], wr_log[$], wd_log[$], stall_log[$];
    logic [31:0] exp_q[$];

    function automatic logic [31:0] init_word(input int a);
        return 32'hA5A5_0000 + 32'(a - 32'h40);
    endfunction

    function automatic logic [31:0] bmem_rd(input int a);
        return bmem.exists(a) ? bmem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] gold_rd(input int a);
        return gold.exists(a) ? gold[a] : init_word(a);
    endfunction

    initial begin : mem_resp
        dwait = 1'b0;
        dload = '0;
        forever begin
            @(negedge CLK);
            if (dREN && dWEN) both_err++;
            case (mem_mode)
                0: dwait = 1'b0;
                1: dwait = ($urandom_range(0, 3) == 0);
                default: begin
                    if (dREN && stall_left > 0) begin
                        dwait = 1'b1;
                        stall_left--;
                        stall_log.push_back(daddr);
                    end else begin
                        dwait = 1'b0;
                    end
                end
            endcase
            dload = bmem_rd(int'(daddr[31:2]));
            if (!dwait && dWEN) begin
                bmem[int'(daddr[31:2])] = dstore;
                wr_count++;
                wr_log.push_back(daddr);
                wd_log.push_back(dstore);
            end
            if (!dwait && dREN) begin
                rd_count++;
                rd_log.push_back(daddr);
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int blk;
        bit dirty;
    } line_t;

    line_t m_set [SETS][$];   // front = most recently used
    bit    link_v;
    int    link_a;

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) m_set[s].delete();
        link_v = 1'b0;
        link_a = 0;
    endfunction

    function automatic void model_access(input bit is_wr, input bit atomic, input int waddr,
                                         input logic [31:0] wdata, output logic [31:0] exp_rd,
                                         output bit hit, output bit wb, output bit fast);
        int    blk, s, pos;
        line_t ln;
        bit    match;
        exp_rd = '0;
        hit    = 1'b0;
        wb     = 1'b0;
        fast   = 1'b0;
        match  = link_v && (link_a == waddr);
        if (is_wr && atomic && !match) begin
            fast = 1'b1;
            return;
        end
        blk = waddr / 2;
        s   = blk % SETS;
        pos = -1;
        for (int i = 0; i < m_set[s].size(); i++)
            if (m_set[s][i].blk == blk) pos = i;
        if (pos >= 0) begin
            hit = 1'b1;
            ln  = m_set[s][pos];
            m_set[s].delete(pos);
        end else begin
            if (m_set[s].size() == 2) begin
                ln = m_set[s].pop_back();
                wb = ln.dirty;
            end
            ln.blk   = blk;
            ln.dirty = 1'b0;
        end
        if (is_wr) begin
            gold[waddr] = wdata;
            ln.dirty    = 1'b1;
            if (atomic) exp_rd = 32'd1;
            if (match) link_v = 1'b0;
        end else begin
            exp_rd = gold_rd(waddr);
            if (atomic) begin
                link_v = 1'b1;
                link_a = waddr;
            end
        end
        m_set[s].push_front(ln);
    endfunction

    // ---------------- drivers ----------------
    task automatic do_access(input bit is_wr, input bit atomic, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata, output int cycles);
        bit got;
        dmemREN   = !is_wr;
        dmemWEN   = is_wr;
        datomic   = atomic;
        dmemaddr  = addr;
        dmemstore = wdata;
        cycles    = 0;
        rdata     = '0;
        got       = 1'b0;
        while (!got && cycles < CYC_LIMIT) begin
            @(negedge CLK); #1;
            cycles++;
            if (dhit) begin
                got   = 1'b1;
                rdata = dmemload;
            end
            @(posedge CLK); #1;
        end
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        datomic = 1'b0;
        check_val("access_done", 32'(got), 32'd1);
    endtask

    task automatic run_op(input bit is_wr, input bit atomic, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag, input bit chk_cyc, input int extra);
        logic [31:0] exp_rd, rdata;
        bit          hit, wb, fast;
        int          cycles, r0, w0, exp_cyc;
        model_access(is_wr, atomic, int'(addr[31:2]), wdata, exp_rd, hit, wb, fast);
        r0 = rd_count;
        w0 = wr_count;
        do_access(is_wr, atomic, addr, wdata, rdata, cycles);
        if (!is_wr || atomic) check_val({tag, "_data"}, rdata, exp_rd);
        exp_cyc = (hit || fast) ? 1 : (wb ? 6 : 4);
        if (chk_cyc) check_val({tag, "_cycles"}, 32'(cycles), 32'(exp_cyc + extra));
        check_val({tag, "_wb_words"}, 32'(wr_count - w0), wb ? 32'd2 : 32'd0);
        check_val({tag, "_fill_words"}, 32'(rd_count - r0), (hit || fast) ? 32'd0 : 32'd2);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          ndirty, w0, cyc, op, waddr;
        bit          got, saw_hit, found;
        logic [31:0] addr, rdata_unused;

        nRST = 1'b1; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
        dmemaddr = '0; dmemstore = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1 nRST = 1'b0;
        @(negedge CLK); #1;
        check_val("rst_dhit", 32'(dhit), 32'd0);
        check_val("rst_dmemload", dmemload, 32'd0);
        check_val("rst_flushed", 32'(flushed), 32'd0);
        check_val("rst_mem_strobes", {30'd0, dREN, dWEN}, 32'd0);
        check_val("rst_state", 32'(o_state), 32'd0);
        @(posedge CLK); #1;

        // Cold read: two fill words then a hit on the fourth cycle.
        mem_mode = 0;
        rd_log.delete();
        run_op(1'b0, 1'b0, 32'h100, 32'h0, "cold_rd100", 1'b1, 0);
        check_val("cold_fill_count", 32'(rd_log.size()), 32'd2);
        if (rd_log.size() >= 2) begin
            check_val("cold_fill_addr0", rd_log[0], 32'h100);
            check_val("cold_fill_addr1", rd_log[1], 32'h104);
        end

        // Dirty victim write-back.
        run_op(1'b1, 1'b0, 32'h104, 32'hDEAD, "wr104", 1'b1, 0);
        run_op(1'b0, 1'b0, 32'h140, 32'h0, "rd140", 1'b1, 0);
        wr_log.delete();
        wd_log.delete();
        exp_q.delete();
        exp_q.push_back(32'h100); exp_q.push_back(32'hA5A5_0000);
        exp_q.push_back(32'h104); exp_q.push_back(32'h0000_DEAD);
        run_op(1'b0, 1'b0, 32'h180, 32'h0, "rd180_evict", 1'b1, 0);
        check_val("wb_count", 32'(wr_log.size()), 32'd2);
        for (int i = 0; i < 2 && i < wr_log.size(); i++) begin
            check_val("wb_addr", wr_log[i], exp_q.pop_front());
            check_val("wb_data", wd_log[i], exp_q.pop_front());
        end
        run_op(1'b0, 1'b0, 32'h104, 32'h0, "rd104_refetch", 1'b1, 0);

        // Memory stall during the first fill word.
        mem_mode   = 2;
        stall_left = 5;
        stall_log.delete();
        run_op(1'b0, 1'b0, 32'h200, 32'h0, "stall_rd200", 1'b1, 5);
        check_val("stall_cycles_seen", 32'(stall_log.size()), 32'd5);
        foreach (stall_log[i]) check_val("stall_addr_stable", stall_log[i], 32'h200);
        mem_mode = 0;

        // LL/SC pair, then a stale SC.
        run_op(1'b0, 1'b1, 32'h200, 32'h0, "ll200", 1'b1, 0);
        run_op(1'b1, 1'b1, 32'h200, 32'h7, "sc200_ok", 1'b1, 0);
        run_op(1'b0, 1'b0, 32'h200, 32'h0, "rd200_after_sc", 1'b1, 0);
        run_op(1'b1, 1'b1, 32'h200, 32'h9, "sc200_stale", 1'b1, 0);
        run_op(1'b0, 1'b0, 32'h200, 32'h0, "rd200_after_stale", 1'b1, 0);

        // Random traffic with random memory waits.
        mem_mode = 1;
        for (int n = 0; n < 400; n++) begin
            waddr = 32'h40 + $urandom_range(0, 3) * 16 + $urandom_range(0, 7) * 2 + $urandom_range(0, 1);
            addr  = 32'(waddr) << 2;
            op    = $urandom_range(0, 9);
            if (op <= 3 || op == 9) begin
                run_op(1'b0, 1'b0, addr, 32'h0, "rnd_rd", 1'b0, 0);
            end else if (op <= 6) begin
                run_op(1'b1, 1'b0, addr, $urandom, "rnd_wr", 1'b0, 0);
            end else if (op == 7) begin
                run_op(1'b0, 1'b1, addr, 32'h0, "rnd_ll", 1'b0, 0);
            end else begin
                if (link_v && $urandom_range(0, 1) == 1) addr = 32'(link_a) << 2;
                run_op(1'b1, 1'b1, addr, $urandom, "rnd_sc", 1'b0, 0);
            end
        end

        // Flush: every dirty frame is written back exactly once.
        ndirty = 0;
        for (int s = 0; s < SETS; s++)
            foreach (m_set[s][i]) if (m_set[s][i].dirty) ndirty++;
        w0      = wr_count;
        saw_hit = 1'b0;
        got     = 1'b0;
        cyc     = 0;
        halt    = 1'b1;
        while (!got && cyc < 2000) begin
            @(negedge CLK); #1;
            cyc++;
            if (dhit) saw_hit = 1'b1;
            if (flushed) got = 1'b1;
            @(posedge CLK); #1;
        end
        check_val("flush_done", 32'(got), 32'd1);
        check_val("flush_wb_words", 32'(wr_count - w0), 32'(2 * ndirty));
        check_val("flush_no_dhit", 32'(saw_hit), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); #1;
            check_val("flushed_held", 32'(flushed), 32'd1);
            check_val("flush_strobes_idle", {30'd0, dREN, dWEN}, 32'd0);
            @(posedge CLK); #1;
        end
        foreach (gold[k]) check_val("mem_after_flush", bmem_rd(k), gold[k]);

        nRST = 1'b1;
        halt = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b0;
        model_reset();
        @(negedge CLK); #1;
        check_val("flushed_cleared", 32'(flushed), 32'd0);
        check_val("post_flush_state", 32'(o_state), 32'd0);
        @(posedge CLK); #1;
        mem_mode = 0;
        run_op(1'b0, 1'b0, 32'h100, 32'h0, "post_reset_rd100", 1'b1, 0);

        // Reset during the second write-back word aborts the miss.
        run_op(1'b1, 1'b0, 32'h100, 32'h1234, "abort_wr100", 1'b1, 0);
        run_op(1'b0, 1'b0, 32'h140, 32'h0, "abort_rd140", 1'b1, 0);
        dmemREN  = 1'b1;
        dmemaddr = 32'h180;
        found    = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK); #1;
            if (dWEN && daddr[2]) begin
                found = 1'b1;
                nRST  = 1'b1;
            end else begin
                @(posedge CLK); #1;
            end
        end
        check_val("abort_reached_wb1", 32'(found), 32'd1);
        @(posedge CLK); #1;
        dmemREN = 1'b0;
        @(negedge CLK); #1;
        check_val("abort_dwen", 32'(dWEN), 32'd0);
        check_val("abort_dren", 32'(dREN), 32'd0);
        check_val("abort_state", 32'(o_state), 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b0;
        model_reset();
        run_op(1'b0, 1'b0, 32'h100, 32'h0, "after_abort_rd100", 1'b1, 0);
        do_access(1'b0, 1'b0, 32'h100, 32'h0, rdata_unused, cyc);
        check_val("after_abort_hit_cycles", 32'(cyc), 32'd1);

        check_val("no_dual_strobe", 32'(both_err), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
